// File: rtl/sccb_clock_gen_if.sv
// Tick/phase/SIOC bundle between the SCCB timebase and its consumer.
// The master side drives the timing outputs; the slave side drives enable.
interface sccb_clock_gen_if;
  logic       enable;
  logic       tick;
  logic [1:0] phase;
  logic       sioc;

  modport master (
    input  enable,
    output tick,
    output phase,
    output sioc
  );

  modport slave (
    output enable,
    input  tick,
    input  phase,
    input  sioc
  );
endinterface

// File: rtl/sccb_clock_gen.sv
// SCCB timebase: divides clk down to a one-cycle tick strobe every DIV
// enabled cycles, advances a quarter-phase index on each tick and derives
// the SIOC level from it (high in phases 0/1, low in phases 2/3).
module sccb_clock_gen #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int TICK_FREQ_HZ = 50_000
) (
  input  logic             clk,
  input  logic             reset,
  sccb_clock_gen_if.master bus
);

  localparam int DIV   = (TICK_FREQ_HZ > 0) ? (CLK_FREQ_HZ / TICK_FREQ_HZ) : 0;
  // Width is clamped to 1 so an illegal divider still elaborates far enough
  // to reach the error below instead of failing on a zero-width vector.
  localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("sccb_clock_gen: DIV = CLK_FREQ_HZ / TICK_FREQ_HZ must be >= 2");
    end
    if (TICK_FREQ_HZ > CLK_FREQ_HZ / 2) begin : g_freq_check
      $error("sccb_clock_gen: TICK_FREQ_HZ must not exceed CLK_FREQ_HZ / 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             tick_q,  tick_d;
  logic [1:0]       phase_q, phase_d;
  logic             sioc_q,  sioc_d;
  logic [1:0]       phase_inc;

  assign phase_inc = phase_q + 2'd1;

  // Next-state: count while enabled, wrap and strobe at terminal count.
  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    sioc_d  = sioc_q;
    if (bus.enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        phase_d = phase_inc;
        sioc_d  = ~phase_inc[1];
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State register; reset overrides enable and suppresses a pending tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= 2'd0;
      sioc_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      sioc_q  <= sioc_d;
    end
  end

  assign bus.tick  = tick_q;
  assign bus.phase = phase_q;
  assign bus.sioc  = sioc_q;

endmodule

// File: tb/tb_sccb_clock_gen.sv
// Bench for sccb_clock_gen: a default-rate instance (DIV=1000) and a
// small-divider instance (DIV=4) run side by side against an arithmetic
// reference model that tracks enabled cycles since reset.
module tb_sccb_clock_gen;

  logic clk;
  logic reset;

  sccb_clock_gen_if if0 ();
  sccb_clock_gen_if if1 ();

  sccb_clock_gen #(.CLK_FREQ_HZ(50_000_000), .TICK_FREQ_HZ(50_000)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.master)
  );

  sccb_clock_gen #(.CLK_FREQ_HZ(8), .TICK_FREQ_HZ(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_total = 0;
  int     n_pass  = 0;

  // Reference model: enabled edges since reset, and the expected strobe.
  longint en_edges [2];
  logic   exp_tick [2];
  longint div_of   [2];

  // Edge index since reset release and the edges at which dut0 ticked.
  int     edge_idx;
  int     tick_edges [$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input logic rst, input logic en);
    longint ticks;
    logic   obs_tick [2];
    logic [1:0] obs_phase [2];
    logic   obs_sioc [2];
    reset      = rst;
    if0.enable = en;
    if1.enable = en;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        en_edges[i] = 0;
        exp_tick[i] = 1'b0;
      end else if (en) begin
        en_edges[i]++;
        exp_tick[i] = (en_edges[i] % div_of[i]) == 0;
      end else begin
        exp_tick[i] = 1'b0;
      end
    end
    if (rst) edge_idx = 0;
    else     edge_idx++;
    #1;
    obs_tick[0] = if0.tick;  obs_phase[0] = if0.phase; obs_sioc[0] = if0.sioc;
    obs_tick[1] = if1.tick;  obs_phase[1] = if1.phase; obs_sioc[1] = if1.sioc;
    if (!rst && obs_tick[0]) tick_edges.push_back(edge_idx);
    for (int i = 0; i < 2; i++) begin
      ticks = en_edges[i] / div_of[i];
      check($sformatf("tick[%0d]", i),  longint'(obs_tick[i]),  longint'(exp_tick[i]));
      check($sformatf("phase[%0d]", i), longint'(obs_phase[i]), ticks % 4);
      check($sformatf("sioc[%0d]", i),  longint'(obs_sioc[i]),  ((ticks % 4) < 2) ? 1 : 0);
    end
  endtask

  initial begin
    div_of[0] = 1000;
    div_of[1] = 4;
    en_edges[0] = 0; en_edges[1] = 0;
    exp_tick[0] = 1'b0; exp_tick[1] = 1'b0;
    edge_idx = 0;
    reset = 1'b1;
    if0.enable = 1'b0;
    if1.enable = 1'b0;

    // Free-running after reset: ticks at edges 1000, 2000, 3000.
    repeat (3) step(1'b1, 1'b1);
    check("rst_sioc", longint'(if0.sioc), 1);
    check("rst_phase", longint'(if0.phase), 0);
    tick_edges.delete();
    repeat (3100) step(1'b0, 1'b1);
    check("free_tick_count", tick_edges.size(), 3);
    if (tick_edges.size() == 3) begin
      check("free_tick0", tick_edges[0], 1000);
      check("free_tick1", tick_edges[1], 2000);
      check("free_tick2", tick_edges[2], 3000);
    end

    // Enable gated off for 250 edges starting at edge 500.
    step(1'b1, 1'b1);
    tick_edges.delete();
    repeat (499) step(1'b0, 1'b1);
    repeat (250) step(1'b0, 1'b0);
    repeat (600) step(1'b0, 1'b1);
    check("gate_tick_count", tick_edges.size(), 1);
    if (tick_edges.size() >= 1) check("gate_tick0", tick_edges[0], 1250);

    // Reset on the edge where the counter would wrap.
    step(1'b1, 1'b1);
    tick_edges.delete();
    repeat (999) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("wrap_rst_tick", longint'(if0.tick), 0);
    check("wrap_rst_phase", longint'(if0.phase), 0);
    check("wrap_rst_sioc", longint'(if0.sioc), 1);
    check("wrap_rst_no_tick", tick_edges.size(), 0);
    repeat (1000) step(1'b0, 1'b1);
    check("wrap_rst_next", tick_edges.size(), 1);
    if (tick_edges.size() >= 1) check("wrap_rst_next_edge", tick_edges[0], 1000);

    // Randomized enable/reset traffic against the model.
    for (int k = 0; k < 20000; k++) begin
      logic r, e;
      r = ($urandom_range(0, 999) == 0);
      e = ($urandom_range(0, 9) != 0);
      step(r, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
